// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: bus widths, fetch FSM states and the
// opcode field layout that fetch and decode agree on.
package cpu_pkg;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 8;
   localparam int LONG_BIT = 7;

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_ARG = 2'd1,
      HOLD      = 2'd2
   } fetch_state_t;

   // Opcode layout: [7] long flag, [6:4] operation class, [3:0] register/immediate nibble
   localparam int OPC_CLASS_MSB = 6;
   localparam int OPC_CLASS_LSB = 4;
   localparam int OPC_REG_MSB   = 3;
   localparam int OPC_REG_LSB   = 0;

   function automatic logic opc_is_long(input logic [DATA_W-1:0] opcode);
      return opcode[LONG_BIT];
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: pulls 1- or 2-byte instructions from memory at the current PC,
// drives the PC controls and holds the assembled instruction until decode takes it.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = cpu_pkg::ADDR_W,
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int LONG_BIT = cpu_pkg::LONG_BIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic              pc_en,
   output logic              pc_jump,
   output logic [ADDR_W-1:0] pc_target,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              br_take,
   input  logic [ADDR_W-1:0] br_target,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [DATA_W-1:0] ir_opcode,
   output logic [DATA_W-1:0] ir_operand,
   output logic              ir_long
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic         acc;

   assign mem_addr  = pc_addr;
   assign pc_target = br_target;
   assign ir_valid  = (state == HOLD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= FETCH_OP;
         ir_opcode  <= '0;
         ir_operand <= '0;
         ir_long    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (acc && state == FETCH_OP) begin
            ir_opcode  <= mem_rdata;
            ir_long    <= mem_rdata[LONG_BIT];
            ir_operand <= '0;
         end
         if (acc && state == FETCH_ARG) begin
            ir_operand <= mem_rdata;
         end
      end
   end

   // A taken branch overrides everything, including a byte arriving the same cycle.
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      pc_en     = 1'b0;
      pc_jump   = 1'b0;
      acc       = 1'b0;
      if (rst) begin
         if (br_take) begin
            pc_en     = 1'b1;
            pc_jump   = 1'b1;
            state_nxt = FETCH_OP;
         end else begin
            mem_req = (state != HOLD);
            acc     = mem_req & mem_ack;
            pc_en   = acc;
            case (state)
               FETCH_OP:  if (acc) state_nxt = mem_rdata[LONG_BIT] ? FETCH_ARG : HOLD;
               FETCH_ARG: if (acc) state_nxt = HOLD;
               HOLD:      if (ir_ready) state_nxt = FETCH_OP;
               default:   state_nxt = FETCH_OP;
            endcase
         end
      end
   end

endmodule
